// File: rtl/main_memory.sv
// Word-addressed main memory for the Mic-1 datapath: one-cycle read latency, write-first,
// zeroed by a sweep after every reset. Optional MEM_ADDR_CHECK_EN adds out-of-range rejection.
module main_memory #(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] mem_addr,
  input  logic [NBITS-1:0] mem_wdata,
  input  logic             write_enb,
  input  logic             read_enb,
  output logic [NBITS-1:0] mem_rdata,
  output logic             rdata_valid,
`ifdef MEM_ADDR_CHECK_EN
  output logic             addr_err,
`endif
  output logic             busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LastIdx = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]  rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [NBITS-1:0]  mem_q [Depth];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [NBITS-1:0]  wr_data;
  logic [ADDR_W-1:0] idx;
  logic              addr_bad;

  assign idx = mem_addr[ADDR_W-1:0];

`ifdef MEM_ADDR_CHECK_EN
  assign addr_bad = |mem_addr[NBITS-1:ADDR_W];
  assign addr_err = err_q;
`else
  // Upper address bits alias; keep them visibly consumed.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{mem_addr[NBITS-1:ADDR_W], err_q};
  assign addr_bad       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_data = mem_wdata;

    unique case (state_q)
      StClear: begin
        wr_en   = 1'b1;
        wr_idx  = cnt_q[ADDR_W-1:0];
        wr_data = '0;
        if (cnt_q == LastIdx) begin
          state_d = StReady;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StReady: begin
        if (addr_bad) begin
          err_d = read_enb | write_enb;
          if (read_enb) begin
            valid_d = 1'b1;
            rdata_d = '0;
          end
        end else begin
          wr_en = write_enb;
          if (read_enb) begin
            valid_d = 1'b1;
            // Write-first: a same-edge write wins over the stored word.
            rdata_d = write_enb ? mem_wdata : mem_q[idx];
          end
        end
      end
      default: state_d = StClear;
    endcase

    if (reset) begin
      state_d = StClear;
      cnt_d   = '0;
      rdata_d = '0;
      valid_d = 1'b0;
      busy_d  = 1'b1;
      err_d   = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    rdata_q <= rdata_d;
    valid_q <= valid_d;
    busy_q  <= busy_d;
    err_q   <= err_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign mem_rdata   = rdata_q;
  assign rdata_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_main_memory.sv
// Directed self-checking bench for main_memory with ADDR_W=4 (16 words).
module tb_main_memory;

  localparam int unsigned NBITS  = 32;
  localparam int unsigned ADDR_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NBITS-1:0] mem_addr;
  logic [NBITS-1:0] mem_wdata;
  logic             write_enb;
  logic             read_enb;
  logic [NBITS-1:0] mem_rdata;
  logic             rdata_valid;
  logic             busy;
`ifdef MEM_ADDR_CHECK_EN
  logic             addr_err;
`endif

  int total = 0;
  int bad   = 0;

  main_memory #(
    .NBITS (NBITS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .mem_rdata  (mem_rdata),
    .rdata_valid(rdata_valid),
`ifdef MEM_ADDR_CHECK_EN
    .addr_err   (addr_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_enb  = 1'b0;
    write_enb = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic exp_v, input logic [NBITS-1:0] exp_d);
    total++;
    if (rdata_valid !== exp_v || (exp_v && mem_rdata !== exp_d)) begin
      bad++;
      $display("FAIL %s: valid=%b data=%h, expected valid=%b data=%h",
               name, rdata_valid, mem_rdata, exp_v, exp_d);
    end
  endtask

  // Count cycles from now until busy drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
      total++;
      if (rdata_valid !== 1'b0) begin
        bad++;
        $display("FAIL clear_valid: rdata_valid=%b during sweep, expected 0", rdata_valid);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    idle();
    mem_addr  = '0;
    mem_wdata = '0;
    reset     = 1'b1;
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || rdata_valid !== 1'b0 || mem_rdata !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b valid=%b data=%h, expected 1 0 0",
               busy, rdata_valid, mem_rdata);
    end
    reset = 1'b0;
    count_busy(n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL clear_len: busy cycles=%0d, expected 16", n);
    end
    for (int a = 0; a < 16; a++) begin
      mem_addr = a;
      read_enb = 1'b1;
      tick();
      check_rd("read_zero", 1'b1, '0);
    end
    idle();
    tick();
    check_rd("idle_no_valid", 1'b0, '0);
  endtask

  task automatic test_write_read();
    mem_addr  = 5;
    mem_wdata = 32'hDEADBEEF;
    write_enb = 1'b1;
    tick();
    check_rd("write_no_valid", 1'b0, '0);
    write_enb = 1'b0;
    read_enb  = 1'b1;
    tick();
    check_rd("read_after_write", 1'b1, 32'hDEADBEEF);
    idle();
    tick();
    total++;
    if (rdata_valid !== 1'b0 || mem_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL hold: valid=%b data=%h, expected 0 deadbeef", rdata_valid, mem_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++) begin
      mem_addr  = a;
      mem_wdata = 32'h10 + a;
      write_enb = 1'b1;
      tick();
    end
    write_enb = 1'b0;
    read_enb  = 1'b1;
    for (int a = 0; a < 4; a++) begin
      mem_addr = a;
      tick();
      check_rd("b2b_read", 1'b1, 32'h10 + a);
    end
    idle();
  endtask

  task automatic test_write_first();
    mem_addr  = 7;
    mem_wdata = 32'h1234;
    write_enb = 1'b1;
    read_enb  = 1'b1;
    tick();
    check_rd("write_first", 1'b1, 32'h1234);
    write_enb = 1'b0;
    mem_wdata = 32'hFFFF;
    tick();
    check_rd("write_first_stored", 1'b1, 32'h1234);
    idle();
  endtask

  task automatic test_reset_mid();
    int n;
    mem_addr  = 2;
    mem_wdata = 32'hAA;
    write_enb = 1'b1;
    tick();
    write_enb = 1'b0;
    read_enb  = 1'b1;
    reset     = 1'b1;
    tick();
    total++;
    if (rdata_valid !== 1'b0 || mem_rdata !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_read: valid=%b data=%h busy=%b, expected 0 0 1",
               rdata_valid, mem_rdata, busy);
    end
    reset = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    write_enb = 1'b1;
    mem_wdata = 32'hBAD;
    count_busy(n);
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL reclear_len: busy cycles=%0d, expected 16", n);
    end
    idle();
    mem_addr = 2;
    read_enb = 1'b1;
    tick();
    check_rd("reclear_addr2", 1'b1, '0);
    idle();
  endtask

  task automatic test_addr_check();
    mem_addr  = 32'h13;
    mem_wdata = 32'h55;
    write_enb = 1'b1;
    tick();
`ifdef MEM_ADDR_CHECK_EN
    total++;
    if (addr_err !== 1'b1) begin
      bad++;
      $display("FAIL addr_err_pulse: addr_err=%b, expected 1", addr_err);
    end
`endif
    write_enb = 1'b0;
    read_enb  = 1'b1;
    mem_addr  = 3;
    tick();
`ifdef MEM_ADDR_CHECK_EN
    check_rd("addr3_unchanged", 1'b1, '0);
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL addr_err_clear: addr_err=%b, expected 0", addr_err);
    end
`else
    check_rd("addr3_alias", 1'b1, 32'h55);
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_first();
    test_reset_mid();
    test_addr_check();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory.md
# main_memory

Word-addressed main memory that answers the Mic-1 datapath's memory port. It accepts word reads and writes issued by the microinstruction MEM field, returns read data with a fixed one-cycle latency, and clears its contents after every reset. It sits outside the datapath and connects directly to the datapath's memory address, write-data, write-enable and read-data signals.

## Interface
- NBITS, 32, width of address and data busses (matches datapath)
- ADDR_W, 10, word-address bits actually decoded; depth = 2^ADDR_W words

- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- mem_addr  input  NBITS  word address from datapath
- mem_wdata  input  NBITS  write data (datapath mem_out)
- write_enb  input  1  write request, one word per cycle
- read_enb  input  1  read request, one word per cycle
- mem_rdata  output  NBITS  read data (datapath mem_in)
- rdata_valid  output  1  one-cycle pulse, mem_rdata holds new read result
- busy  output  1  high while clear sweep runs; requests ignored

## Operation
- Storage: 2^ADDR_W words of NBITS; index = mem_addr[ADDR_W-1:0].
- FSM states: CLEAR, READY.
  - reset=1 at an edge: state <= CLEAR, sweep counter <= 0, mem_rdata <= 0, rdata_valid <= 0, busy <= 1.
  - CLEAR: writes 0 to word[counter] each cycle, counter+1; when counter = 2^ADDR_W-1 is written, state <= READY, busy <= 0 at next edge.
  - READY: serves requests; stays until reset.
- In CLEAR, read_enb/write_enb are ignored (no write, no rdata_valid).
- Write (READY, write_enb=1): word[index] <= mem_wdata at that edge.
- Read (READY, read_enb=1): mem_rdata <= word[index], rdata_valid <= 1 at that edge.
- Simultaneous read_enb and write_enb: write performed; read returns mem_wdata (write-first).
- Read of an address written in the previous cycle returns the new value.
- No read issued: rdata_valid <= 0, mem_rdata holds its last value.
- Counter width ADDR_W+1 bits; no wrap beyond the final word.

## Timing
- Reset values: mem_rdata=0, rdata_valid=0, busy=1.
- Clear duration: busy high for exactly 2^ADDR_W cycles after the last edge with reset=1.
- Read latency: request sampled at edge k, data and rdata_valid valid from edge k through edge k+1 (visible to datapath during cycle k+1, MDR loads at end of that cycle).
- Throughput: one read or write (or both) per cycle, fully pipelined; back-to-back reads give back-to-back valid pulses.
- Write latency: stored at edge k, visible to any read sampled at edge k+1 or later, and to a same-edge read via write-first.
- Reset mid-operation (CLEAR or READY): pending read result discarded, sweep restarts from word 0.

## Configuration
- MEM_ADDR_CHECK_EN defined: adds output addr_err (1 bit, reset 0). In READY, any request with mem_addr[NBITS-1:ADDR_W] != 0 is rejected: no write, read returns mem_rdata=0 with rdata_valid=1, addr_err pulses high for one cycle aligned with that edge. In CLEAR, addr_err stays 0.
- Undefined: no addr_err port; upper address bits are ignored and addresses alias modulo 2^ADDR_W.

## Test plan
- Reset 1 cycle with ADDR_W=4 -> busy=1 for exactly 16 cycles, then 0; read of every address returns 0 with rdata_valid pulse one cycle after request.
- Write 0xDEADBEEF to addr 5, read addr 5 next cycle -> mem_rdata=0xDEADBEEF, rdata_valid=1 in the following cycle.
- Write addrs 0..3 with 0x10..0x13, then 4 consecutive reads -> 4 consecutive valid cycles returning 0x10,0x11,0x12,0x13.
- read_enb=write_enb=1, addr 7, wdata 0x1234 (old value 0) -> mem_rdata=0x1234; later read addr 7 -> 0x1234.
- Write addr 2 = 0xAA, assert reset for 1 cycle during a read and again at sweep count 3 -> rdata_valid=0 after reset, busy lasts full 16 cycles from last reset, addr 2 reads 0.
- With MEM_ADDR_CHECK_EN, ADDR_W=4: write 0x55 to 0x13 -> addr_err pulse, addr 3 unchanged; without it, addr 3 reads 0x55.
